// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider and enable freeze.
// Define VGA_FRAME_COUNTER_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          pix_stb,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  localparam logic [31:0] H_VIS  = 32'(H_VISIBLE);
  localparam logic [31:0] HS_BEG = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] V_VIS  = 32'(V_VISIBLE);
  localparam logic [31:0] VS_BEG = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_bad_hcw
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_vcw
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic          h_wrap, v_wrap;
  logic          h_in_sync, v_in_sync;

  assign h_wrap  = (hpos_q == H_LAST);
  assign v_wrap  = (vpos_q == V_LAST);
  assign pix_stb = enable & (div_q == DIV_LAST);

  always_comb begin
    div_d  = div_q;
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (pix_stb) begin
      hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      div_q  <= div_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Decode straight off the counter registers so every output describes the same pixel.
  assign h_in_sync = (32'(hpos_q) >= HS_BEG) && (32'(hpos_q) < HS_END);
  assign v_in_sync = (32'(vpos_q) >= VS_BEG) && (32'(vpos_q) < VS_END);

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync       = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
  assign display_on  = (32'(hpos_q) < H_VIS) && (32'(vpos_q) < V_VIS);
  assign line_start  = pix_stb & (hpos_q == '0);
  assign frame_start = pix_stb & (hpos_q == '0) & (vpos_q == '0);

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (pix_stb & h_wrap & v_wrap) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, divided, tiny) against a strobe-count model.
// Frame counter checks are active when VGA_FRAME_COUNTER_EN is defined.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       stb;
    logic [9:0] hp;
    logic [9:0] vp;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } exp_t;

  typedef struct {
    int n;
    int hp;
    int vp;
    bit hs;
    bit de;
    bit ls;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  logic       stb_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] hp_a, vp_a;
  logic       stb_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [5:0] hp_b, vp_b;
  logic       stb_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [3:0] hp_c, vp_c;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fc_a, fc_b, fc_c;
`endif

  int nchk = 0;
  int nerr = 0;
  int cnt  = 0;
  bit obs_ls_a, obs_fs_b;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_stb(stb_a), .hpos(hp_a), .vpos(vp_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(3), .CW(6)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_stb(stb_b), .hpos(hp_b), .vpos(vp_b),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .CW(4)
  ) dut_c (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_stb(stb_c), .hpos(hp_c), .vpos(vp_c),
    .hsync(hs_c), .vsync(vs_c), .display_on(de_c),
    .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_c)
`endif
  );

  // Expected outputs from the count of enabled clocks since reset.
  function automatic exp_t model(input int hv, hf, hs, hb,
                                 input int vv, vf, vs, vb,
                                 input bit hpol, vpol,
                                 input int dv, c, input bit en);
    exp_t e;
    int ht, vt, n, h, v;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    n  = c / dv;
    h  = n % ht;
    v  = (n / ht) % vt;
    e.stb = en && ((c % dv) == dv - 1);
    e.hp  = 10'(h);
    e.vp  = 10'(v);
    e.hs  = (h >= hv + hf && h < hv + hf + hs) ? hpol : !hpol;
    e.vs  = (v >= vv + vf && v < vv + vf + vs) ? vpol : !vpol;
    e.de  = (h < hv) && (v < vv);
    e.ls  = e.stb && (h == 0);
    e.fs  = e.stb && (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t pack(input bit stb, input int hp, vp,
                                input bit hs, vs, de, ls, fs);
    exp_t e;
    e = '{stb: stb, hp: 10'(hp), vp: 10'(vp), hs: hs,
          vs: vs, de: de, ls: ls, fs: fs};
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb(input string name, input exp_t act, input exp_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL sb_%s c=%0d got=%h expected=%h", name, cnt, act, exp);
    end
  endtask

  // One clock: drive, push expectations, compare mid-cycle, advance at edge.
  task automatic step(input bit en);
    exp_t e;
    enable = en;
    qa.push_back(model(640, 16, 96, 48, 480, 10, 2, 33,
                       1'b0, 1'b0, 1, cnt, en));
    qb.push_back(model(8, 2, 3, 2, 4, 1, 2, 1,
                       1'b1, 1'b1, 3, cnt, en));
    qc.push_back(model(4, 1, 1, 1, 2, 1, 1, 1,
                       1'b0, 1'b0, 1, cnt, en));
    #3;
    e = qa.pop_front();
    sb("A", pack(stb_a, int'(hp_a), int'(vp_a), hs_a, vs_a,
                 de_a, ls_a, fs_a), e);
    e = qb.pop_front();
    sb("B", pack(stb_b, int'(hp_b), int'(vp_b), hs_b, vs_b,
                 de_b, ls_b, fs_b), e);
    e = qc.pop_front();
    sb("C", pack(stb_c, int'(hp_c), int'(vp_c), hs_c, vs_c,
                 de_c, ls_c, fs_c), e);
    obs_ls_a = ls_a;
    obs_fs_b = fs_b;
    @(posedge clk);
    if (en) cnt++;
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int k;
    tbl[0] = '{n: 0,    hp: 0,   vp: 0, hs: 1, de: 1, ls: 1};
    tbl[1] = '{n: 639,  hp: 639, vp: 0, hs: 1, de: 1, ls: 0};
    tbl[2] = '{n: 640,  hp: 640, vp: 0, hs: 1, de: 0, ls: 0};
    tbl[3] = '{n: 655,  hp: 655, vp: 0, hs: 1, de: 0, ls: 0};
    tbl[4] = '{n: 656,  hp: 656, vp: 0, hs: 0, de: 0, ls: 0};
    tbl[5] = '{n: 751,  hp: 751, vp: 0, hs: 0, de: 0, ls: 0};
    tbl[6] = '{n: 752,  hp: 752, vp: 0, hs: 1, de: 0, ls: 0};
    tbl[7] = '{n: 799,  hp: 799, vp: 0, hs: 1, de: 0, ls: 0};
    tbl[8] = '{n: 800,  hp: 0,   vp: 1, hs: 1, de: 1, ls: 1};
    tbl[9] = '{n: 1600, hp: 0,   vp: 2, hs: 1, de: 1, ls: 1};

    rst = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hpos", int'(hp_a), 0);
    chk("rst_vpos", int'(vp_a), 0);
    chk("rst_hsync", int'(hs_a), 1);
    chk("rst_vsync", int'(vs_a), 1);
    chk("rst_display_on", int'(de_a), 1);
    chk("rst_hsync_b", int'(hs_b), 0);
    rst = 1'b0;
    cnt = 0;
    #1;
    chk("first_frame_start", int'(fs_a), 1);

    for (int i = 0; i < 10; i++) begin
      while (cnt < tbl[i].n) step(1'b1);
      chk($sformatf("tbl%0d_hpos", i), int'(hp_a), tbl[i].hp);
      chk($sformatf("tbl%0d_vpos", i), int'(vp_a), tbl[i].vp);
      chk($sformatf("tbl%0d_hsync", i), int'(hs_a), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_de", i), int'(de_a), int'(tbl[i].de));
      chk($sformatf("tbl%0d_ls", i), int'(ls_a), int'(tbl[i].ls));
    end

    step(1'b1);
    k = 0;
    do begin
      step(1'b1);
      k++;
    end while (!obs_ls_a && k < 2000);
    chk("line_start_period", k, 800);

    k = 0;
    do begin
      step(1'b1);
      k++;
    end while (!obs_fs_b && k < 500);
    chk("b_first_fs_found", int'(obs_fs_b), 1);
    k = 0;
    do begin
      step(1'b1);
      k++;
    end while (!obs_fs_b && k < 500);
    chk("b_frame_period", k, 360);

    k = 0;
    repeat (50) begin
      step(1'b1);
      k++;
    end
    repeat (10) begin
      step(1'b0);
      k++;
    end
    while (!obs_fs_b && k < 600) begin
      step(1'b1);
      k++;
    end
    chk("b_frame_period_frozen", k, 370);

    while ((cnt % 800) != 300) step(1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_hpos", int'(hp_a), 0);
    chk("arst_vpos", int'(vp_a), 0);
    chk("arst_hsync", int'(hs_a), 1);
    chk("arst_display_on", int'(de_a), 1);
    chk("arst_hpos_b", int'(hp_b), 0);
    chk("arst_hpos_c", int'(hp_c), 0);
    #1 rst = 1'b0;
    cnt = 0;
    #1;
    chk("arst_frame_start", int'(fs_a), 1);

    while (cnt < 35) step(1'b1);
`ifdef VGA_FRAME_COUNTER_EN
    chk("fcnt_one", int'(fc_c), 1);
    chk("fcnt_a_zero", int'(fc_a), 0);
`endif
    while (cnt < 255 * 35) step(1'b1);
`ifdef VGA_FRAME_COUNTER_EN
    chk("fcnt_255", int'(fc_c), 255);
`endif
    while (cnt < 256 * 35) step(1'b1);
`ifdef VGA_FRAME_COUNTER_EN
    chk("fcnt_wrap", int'(fc_c), 0);
`endif
    chk("c_frame_start_wrap", int'(fs_c), 1);
    repeat (20) step(1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
